// File: rtl/cache_tag_ctrl.sv
// Lookup/control stage in front of a 2-way, 512-set tag array.
// Clears the array after reset, then services one address request at a time:
// reads the set, compares both ways, reports hit/miss with hit or victim way,
// tracks per-set LRU, marks lines dirty on store hits and installs refilled tags.
module cache_tag_ctrl #(
    parameter int unsigned ADDR_WIDTH   = 9,
    parameter int unsigned TAG_WIDTH    = 17,
    parameter int unsigned OFFSET_WIDTH = 6,
    parameter int unsigned DATA_WIDTH   = 38
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [31:0]           req_addr,
    input  logic                  req_is_write,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic                  resp_hit,
    output logic                  resp_way,
    output logic                  resp_victim_dirty,
    output logic [TAG_WIDTH-1:0]  resp_victim_tag,
    input  logic                  refill_done,
    output logic                  tag_ce,
    output logic                  tag_we,
    output logic [ADDR_WIDTH-1:0] tag_raddr,
    output logic [ADDR_WIDTH-1:0] tag_waddr,
    output logic [DATA_WIDTH-1:0] tag_din,
    output logic [DATA_WIDTH-1:0] tag_wmask,
    input  logic [DATA_WIDTH-1:0] tag_dout
);

    localparam int unsigned WAY_W    = TAG_WIDTH + 2;
    localparam int unsigned NUM_SETS = 1 << ADDR_WIDTH;
    localparam int unsigned TAG_LSB  = OFFSET_WIDTH + ADDR_WIDTH;
    localparam int unsigned VALID_B  = TAG_WIDTH + 1;
    localparam int unsigned DIRTY_B  = TAG_WIDTH;

    localparam logic [DATA_WIDTH-1:0] WAY0_MASK   = {{(DATA_WIDTH-WAY_W){1'b0}}, {WAY_W{1'b1}}};
    localparam logic [DATA_WIDTH-1:0] WAY1_MASK   = ~WAY0_MASK;
    localparam logic [DATA_WIDTH-1:0] DIRTY0_MASK = {{(DATA_WIDTH-1){1'b0}}, 1'b1} << DIRTY_B;
    localparam logic [DATA_WIDTH-1:0] DIRTY1_MASK = {{(DATA_WIDTH-1){1'b0}}, 1'b1} << (WAY_W + DIRTY_B);

    typedef enum logic [2:0] {
        INIT,
        IDLE,
        LOOKUP,
        RESP,
        MISS
    } state_t;

    state_t                  state;
    logic [ADDR_WIDTH-1:0]   init_cnt;
    logic [NUM_SETS-1:0]     lru;
    logic [ADDR_WIDTH-1:0]   req_index;
    logic [TAG_WIDTH-1:0]    req_tag;
    logic                    req_wr;
    logic [DATA_WIDTH-1:0]   entry_q;

    // Only the tag and index fields of the address matter to this stage.
    logic unused_offset;
    assign unused_offset = ^req_addr[OFFSET_WIDTH-1:0];

    // Decode of the set read back from the array while in LOOKUP.
    logic [WAY_W-1:0]     rd_way0;
    logic [WAY_W-1:0]     rd_way1;
    logic                 hit0;
    logic                 hit1;
    logic                 hit_any;
    logic                 victim;
    logic [WAY_W-1:0]     victim_entry;
    logic                 lookup_way;

    // Way compare and victim selection on the freshly read set.
    always_comb begin
        rd_way0      = tag_dout[WAY_W-1:0];
        rd_way1      = tag_dout[DATA_WIDTH-1:WAY_W];
        hit0         = rd_way0[VALID_B] && (rd_way0[TAG_WIDTH-1:0] == req_tag);
        hit1         = rd_way1[VALID_B] && (rd_way1[TAG_WIDTH-1:0] == req_tag);
        hit_any      = hit0 || hit1;
        if (!rd_way0[VALID_B]) begin
            victim = 1'b0;
        end else if (!rd_way1[VALID_B]) begin
            victim = 1'b1;
        end else begin
            victim = lru[req_index];
        end
        victim_entry = victim ? rd_way1 : rd_way0;
        if (hit0) begin
            lookup_way = 1'b0;
        end else if (hit1) begin
            lookup_way = 1'b1;
        end else begin
            lookup_way = victim;
        end
    end

    // Write-side decode for the two update paths out of RESP and MISS.
    logic                 hit_dirty;
    logic                 dirty_fire;
    logic                 refill_fire;
    logic [WAY_W-1:0]     new_entry;

    always_comb begin
        hit_dirty   = resp_way ? entry_q[WAY_W + DIRTY_B] : entry_q[DIRTY_B];
        dirty_fire  = (state == RESP) && resp_ready && resp_hit && req_wr && !hit_dirty;
        refill_fire = (state == MISS) && refill_done;
        new_entry   = {1'b1, req_wr, req_tag};
    end

    // Main control FSM; handshake and response outputs are registered here.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state             <= INIT;
            init_cnt          <= '0;
            lru               <= '0;
            req_index         <= '0;
            req_tag           <= '0;
            req_wr            <= 1'b0;
            entry_q           <= '0;
            req_ready         <= 1'b0;
            resp_valid        <= 1'b0;
            resp_hit          <= 1'b0;
            resp_way          <= 1'b0;
            resp_victim_dirty <= 1'b0;
            resp_victim_tag   <= '0;
        end else begin
            case (state)
                INIT: begin
                    init_cnt <= init_cnt + 1'b1;
                    if (init_cnt == '1) begin
                        state     <= IDLE;
                        req_ready <= 1'b1;
                    end
                end
                IDLE: begin
                    if (req_valid) begin
                        req_index <= req_addr[TAG_LSB-1:OFFSET_WIDTH];
                        req_tag   <= req_addr[TAG_LSB +: TAG_WIDTH];
                        req_wr    <= req_is_write;
                        req_ready <= 1'b0;
                        state     <= LOOKUP;
                    end
                end
                LOOKUP: begin
                    resp_valid        <= 1'b1;
                    resp_hit          <= hit_any;
                    resp_way          <= lookup_way;
                    resp_victim_dirty <= !hit_any && victim_entry[VALID_B] && victim_entry[DIRTY_B];
                    resp_victim_tag   <= hit_any ? '0 : victim_entry[TAG_WIDTH-1:0];
                    entry_q           <= tag_dout;
                    state             <= RESP;
                end
                RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        if (resp_hit) begin
                            lru[req_index] <= ~resp_way;
                            req_ready      <= 1'b1;
                            state          <= IDLE;
                        end else begin
                            state <= MISS;
                        end
                    end
                end
                MISS: begin
                    if (refill_done) begin
                        lru[req_index] <= ~resp_way;
                        req_ready      <= 1'b1;
                        state          <= IDLE;
                    end
                end
                default: begin
                    state     <= INIT;
                    init_cnt  <= '0;
                    req_ready <= 1'b0;
                end
            endcase
        end
    end

    // Tag array port drive. The read address must follow req_addr in the
    // accept cycle, so these are decoded from state rather than registered;
    // they are held at zero while reset is asserted.
    always_comb begin
        tag_ce    = 1'b0;
        tag_we    = 1'b0;
        tag_raddr = '0;
        tag_waddr = '0;
        tag_din   = '0;
        tag_wmask = '0;
        if (reset_n) begin
            case (state)
                INIT: begin
                    tag_ce    = 1'b1;
                    tag_we    = 1'b1;
                    tag_waddr = init_cnt;
                    tag_wmask = '1;
                end
                IDLE: begin
                    if (req_valid) begin
                        tag_ce    = 1'b1;
                        tag_raddr = req_addr[TAG_LSB-1:OFFSET_WIDTH];
                    end
                end
                RESP: begin
                    if (dirty_fire) begin
                        tag_ce    = 1'b1;
                        tag_we    = 1'b1;
                        tag_waddr = req_index;
                        tag_wmask = resp_way ? DIRTY1_MASK : DIRTY0_MASK;
                        tag_din   = entry_q | tag_wmask;
                    end
                end
                MISS: begin
                    if (refill_fire) begin
                        tag_ce    = 1'b1;
                        tag_we    = 1'b1;
                        tag_waddr = req_index;
                        tag_wmask = resp_way ? WAY1_MASK : WAY0_MASK;
                        tag_din   = resp_way ? {new_entry, entry_q[WAY_W-1:0]}
                                             : {entry_q[DATA_WIDTH-1:WAY_W], new_entry};
                    end
                end
                default: begin
                    tag_ce = 1'b0;
                end
            endcase
        end
    end

    // Structural invariants of the control handshake.
    a_we_implies_ce: assert property (@(posedge clock) disable iff (!reset_n)
        tag_we |-> tag_ce);
    a_ready_resp_excl: assert property (@(posedge clock) disable iff (!reset_n)
        !(req_ready && resp_valid));

endmodule
